// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // At least one bit so that N=1 still has a (constant-zero) counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor d = x - y - bin, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_nbit
  import serial_arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state, state_nx;
  logic [N-1:0]   xs, ys, dsr, dsr_nx;
  logic           b, b_nx, di;
  logic [CW-1:0]  cnt;
  logic           last, accept;
`ifdef SUB_OVERFLOW_EN
  logic           xmsb, ymsb;
`endif

  full_subtractor u_fs (
    .x    (xs[0]),
    .y    (ys[0]),
    .bin  (b),
    .d    (di),
    .bout (b_nx)
  );

  always_comb begin
    last   = (cnt == CW'(N - 1));
    accept = start && (state != ST_RUN);
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    dsr_nx       = dsr >> 1;
    dsr_nx[N-1]  = di;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = start ? ST_RUN : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Results are published from the next-value of the working registers so they
  // appear exactly on entry to DONE; the previous result stays visible during RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      xs   <= '0;
      ys   <= '0;
      dsr  <= '0;
      b    <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      xmsb <= 1'b0;
      ymsb <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      xs   <= x;
      ys   <= y;
      b    <= bin;
      cnt  <= '0;
`ifdef SUB_OVERFLOW_EN
      xmsb <= x[N-1];
      ymsb <= y[N-1];
`endif
    end else if (state == ST_RUN) begin
      xs  <= xs >> 1;
      ys  <= ys >> 1;
      dsr <= dsr_nx;
      b   <= b_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        d    <= dsr_nx;
        bout <= b_nx;
`ifdef SUB_OVERFLOW_EN
        ovf  <= (xmsb ^ ymsb) & (xmsb ^ dsr_nx[N-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit (N=8 and N=1 instances),
// table vectors, corner-case sequences and randomized ops against a model.
module tb_serial_subtractor_nbit;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] x8, y8, d8;
  logic       start1, x1, y1, bin1, busy1, done1, d1, bout1;
`ifdef SUB_OVERFLOW_EN
  logic       ovf8, ovf1;
`endif

  int checks    = 0;
  int errors    = 0;
  int done_cnt8 = 0;
  logic [7:0] exp_prev_d = '0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  vec_t tbl[8];

  serial_subtractor_nbit #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .x(x8), .y(y8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor_nbit #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x(x1), .y(y1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done8 === 1'b1) done_cnt8++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Unsigned difference modulo 2^w; borrow iff the true difference is negative.
  function automatic void model(input int unsigned w, input int unsigned x, y, b,
                                output int unsigned d, output bit bo, output bit ov);
    int diff;
    int unsigned xm, ym, dm;
    diff = int'(x) - int'(y) - int'(b);
    d    = diff & ((1 << w) - 1);
    bo   = diff < 0;
    xm   = (x >> (w - 1)) & 1;
    ym   = (y >> (w - 1)) & 1;
    dm   = (d >> (w - 1)) & 1;
    ov   = bit'((xm ^ ym) & (xm ^ dm));
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic b, input bit hold,
                     output logic [7:0] dact, output logic boact, output logic ovact);
    int unsigned ed;
    bit ebo, eov;
    int lat;
    model(W, x, y, b, ed, ebo, eov);
    if (!hold) @(negedge clk);
    x8 = x; y8 = y; bin8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    x8 = $urandom; y8 = $urandom; bin8 = 1'($urandom);
    chk("busy_run", busy8, 1);
    chk("d_hold_run", d8, exp_prev_d);
    lat = 0;
    while (done8 !== 1'b1 && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency8", lat, W);
    chk("d8", d8, ed);
    chk("bout8", bout8, ebo);
    chk("busy_done", busy8, 0);
    dact  = d8;
    boact = bout8;
`ifdef SUB_OVERFLOW_EN
    chk("ovf8", ovf8, eov);
    ovact = ovf8;
`else
    ovact = 1'b0;
`endif
    exp_prev_d = ed[7:0];
  endtask

  initial begin
    logic [7:0] rd;
    logic rbo, rov;
    int lat, n0;
    int unsigned ed;
    bit ebo, eov;

    tbl[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    tbl[1] = '{8'd5,   8'd9,   1'b0, 8'd252, 1'b1};
    tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    tbl[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    tbl[4] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
    tbl[5] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
    tbl[6] = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0};
    tbl[7] = '{8'd200, 8'd50,  1'b0, 8'd150, 1'b0};

    reset = 1'b1;
    start8 = 0; x8 = '0; y8 = '0; bin8 = 0;
    start1 = 0; x1 = 0; y1 = 0; bin1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_d", d8, 0);
    chk("rst_bout", bout8, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_d1", d1, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", ovf8, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      op8(tbl[i].x, tbl[i].y, tbl[i].b, 1'b0, rd, rbo, rov);
      chk("tbl_d", rd, tbl[i].d);
      chk("tbl_bout", rbo, tbl[i].bo);
    end

    // start during RUN is ignored: first result unchanged, one done pulse.
    @(negedge clk);
    x8 = 8'd100; y8 = 8'd37; bin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    n0 = done_cnt8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    x8 = 8'd1; y8 = 8'd1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    chk("ign_busy", busy8, 1);
    lat = 3;
    while (done8 !== 1'b1 && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_latency", lat, W);
    chk("ign_d", d8, 63);
    chk("ign_bout", bout8, 0);
    @(posedge clk); #1;
    chk("ign_done_1cyc", done8, 0);
    chk("ign_idle", busy8, 0);
    repeat (2) @(posedge clk); #1;
    chk("ign_pulses", done_cnt8 - n0, 1);
    exp_prev_d = 8'd63;

    // back-to-back: start held through DONE.
    n0 = done_cnt8;
    op8(8'd10, 8'd3, 1'b0, 1'b0, rd, rbo, rov);
    chk("b2b_first", rd, 7);
    op8(8'd200, 8'd50, 1'b0, 1'b1, rd, rbo, rov);
    chk("b2b_second", rd, 150);
    @(posedge clk); #1;
    chk("b2b_pulses", done_cnt8 - n0, 2);

    // reset in cycle 4 of RUN aborts without a done pulse.
    @(negedge clk);
    x8 = 8'd77; y8 = 8'd11; bin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1;
    n0 = done_cnt8;
    @(posedge clk); #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_d", d8, 0);
    chk("abort_bout", bout8, 0);
    @(negedge clk);
    reset = 0;
    repeat (W + 3) @(posedge clk); #1;
    chk("abort_no_done", done_cnt8 - n0, 0);
    exp_prev_d = '0;
    op8(8'd77, 8'd11, 1'b0, 1'b0, rd, rbo, rov);
    chk("abort_fresh", rd, 66);

`ifdef SUB_OVERFLOW_EN
    op8(8'h80, 8'h01, 1'b0, 1'b0, rd, rbo, rov);
    chk("ovf_80_01_d", rd, 8'h7F);
    chk("ovf_80_01", rov, 1);
    op8(8'h10, 8'h01, 1'b0, 1'b0, rd, rbo, rov);
    chk("ovf_10_01", rov, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), rd, rbo, rov);
    end

    // N=1 exhaustive sweep.
    for (int i = 0; i < 8; i++) begin
      model(1, (i >> 2) & 1, (i >> 1) & 1, i & 1, ed, ebo, eov);
      @(negedge clk);
      x1 = i[2]; y1 = i[1]; bin1 = i[0]; start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      chk("n1_busy", busy1, 1);
      lat = 0;
      while (done1 !== 1'b1 && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("n1_latency", lat, 1);
      chk("n1_d", d1, ed);
      chk("n1_bout", bout1, ebo);
`ifdef SUB_OVERFLOW_EN
      chk("n1_ovf", ovf1, eov);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
